// File: rtl/quad_encoder_gen.sv
// Rotary-encoder emulator: emits Count_I Gray-coded A/B detents in direction Dir_I; outputs registered, first phase one cycle after the handshake.
// Ready_O is high only in IDLE; requests arriving while a command runs are ignored, never queued.
module quad_encoder_gen #(
   parameter int unsigned PHASE_CYC = 4,
   parameter int unsigned GAP_CYC   = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Req_I,
   input  logic [1:0] Dir_I,
   input  logic [7:0] Count_I,
   output logic       Ready_O,
   output logic       SIA,
   output logic       SIB,
   output logic       Busy_O,
   output logic       Step_O,
   output logic       Done_O,
   output logic       Err_O,
   output logic [7:0] Remain_O
);

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4, GAP, DONE} state_t;

   localparam logic [15:0] PH_LOAD  = 16'(PHASE_CYC - 1);
   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [7:0]  remain_q, remain_d;
   logic [1:0]  dir_q, dir_d;
   logic        err_d;
   logic [1:0]  ab_d;
   logic        step_d;
   logic        sia_q, sib_q, step_q, err_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         remain_q <= '0;
         dir_q    <= '0;
         sia_q    <= 1'b1;
         sib_q    <= 1'b1;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
         sia_q    <= ab_d[1];
         sib_q    <= ab_d[0];
         step_q   <= step_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      remain_d = remain_q;
      dir_d    = dir_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req_I) begin
               dir_d    = Dir_I;
               remain_d = Count_I;
               if (Dir_I == 2'b00 || Dir_I == 2'b11) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else if (Count_I == 8'd0) begin
                  state_d = DONE;
               end else begin
                  state_d = PH1;
                  timer_d = PH_LOAD;
               end
            end
         end
         PH1, PH2, PH3: begin
            if (timer_q == 16'd0) begin
               timer_d = PH_LOAD;
               case (state_q)
                  PH1:     state_d = PH2;
                  PH2:     state_d = PH3;
                  default: state_d = PH4;
               endcase
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         PH4: begin
            if (timer_q == 16'd0) begin
               remain_d = remain_q - 8'd1;
               if (remain_q == 8'd1) begin
                  state_d = DONE;
               end else if (GAP_CYC != 0) begin
                  state_d = GAP;
                  timer_d = GAP_LOAD;
               end else begin
                  state_d = PH1;
                  timer_d = PH_LOAD;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         GAP: begin
            if (timer_q == 16'd0) begin
               state_d = PH1;
               timer_d = PH_LOAD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the A/B pins come straight off flops.
   always_comb begin
      ab_d   = 2'b11;
      step_d = (state_d == PH4) && (state_q != PH4);
      case (state_d)
         PH1:     ab_d = (dir_d == 2'b01) ? 2'b10 : 2'b01;
         PH2:     ab_d = 2'b00;
         PH3:     ab_d = (dir_d == 2'b01) ? 2'b01 : 2'b10;
         default: ab_d = 2'b11;
      endcase
   end

   assign SIA      = sia_q;
   assign SIB      = sib_q;
   assign Step_O   = step_q;
   assign Err_O    = err_q;
   assign Ready_O  = (state_q == IDLE);
   assign Busy_O   = (state_q != IDLE);
   assign Done_O   = (state_q == DONE);
   assign Remain_O = remain_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: a per-command expected-trace model checked every cycle,
// literal waveform checks, a rotary-decoder loopback and randomized traffic.
module tb_quad_encoder_gen;

   typedef struct packed {
      logic       a;
      logic       b;
      logic       rdy;
      logic       bsy;
      logic       stp;
      logic       dn;
      logic       er;
      logic [7:0] rem;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst [2];
   logic       req [2];
   logic [1:0] dir [2];
   logic [7:0] cnt [2];

   logic       sia0, sib0, ready0, busy0, step0, done0, err0;
   logic       sia1, sib1, ready1, busy1, step1, done1, err1;
   logic [7:0] rem0, rem1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   quad_encoder_gen #(.PHASE_CYC(4), .GAP_CYC(8)) u_dut (
      .CLK(clk), .RST(rst[0]), .Req_I(req[0]), .Dir_I(dir[0]), .Count_I(cnt[0]),
      .Ready_O(ready0), .SIA(sia0), .SIB(sib0), .Busy_O(busy0), .Step_O(step0),
      .Done_O(done0), .Err_O(err0), .Remain_O(rem0)
   );

   quad_encoder_gen #(.PHASE_CYC(4), .GAP_CYC(0)) u_loop (
      .CLK(clk), .RST(rst[1]), .Req_I(req[1]), .Dir_I(dir[1]), .Count_I(cnt[1]),
      .Ready_O(ready1), .SIA(sia1), .SIB(sib1), .Busy_O(busy1), .Step_O(step1),
      .Done_O(done1), .Err_O(err1), .Remain_O(rem1)
   );

   exp_t act0, act1;
   assign act0 = {sia0, sib0, ready0, busy0, step0, done0, err0, rem0};
   assign act1 = {sia1, sib1, ready1, busy1, step1, done1, err1, rem1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   exp_t q0[$];
   exp_t q1[$];
   exp_t cur [2];
   logic model_on = 1'b0;

   function automatic exp_t mk(input logic a, input logic b, input logic rdy, input logic bsy,
                               input logic stp, input logic dn, input logic er, input logic [7:0] r);
      exp_t e;
      e = {a, b, rdy, bsy, stp, dn, er, r};
      return e;
   endfunction

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Expand one accepted command into the exact per-cycle output trace it must produce.
   task automatic build(input int d, input logic [1:0] dr, input logic [7:0] n);
      int         p;
      int         g;
      logic [1:0] ab [4];
      p = 4;
      g = (d == 0) ? 8 : 0;
      if (dr == 2'b01) begin
         ab[0] = 2'b10; ab[1] = 2'b00; ab[2] = 2'b01; ab[3] = 2'b11;
      end else begin
         ab[0] = 2'b01; ab[1] = 2'b00; ab[2] = 2'b10; ab[3] = 2'b11;
      end
      if (dr == 2'b00 || dr == 2'b11) begin
         push(d, mk(1, 1, 0, 1, 0, 1, 1, n));
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            for (int ph = 0; ph < 4; ph++)
               for (int c = 0; c < p; c++)
                  push(d, mk(ab[ph][1], ab[ph][0], 0, 1, (ph == 3 && c == 0), 0, 0, 8'(int'(n) - i)));
            if (i < int'(n) - 1)
               for (int c = 0; c < g; c++)
                  push(d, mk(1, 1, 0, 1, 0, 0, 0, 8'(int'(n) - i - 1)));
         end
         push(d, mk(1, 1, 0, 1, 0, 1, 0, 8'd0));
      end
   endtask

   task automatic model_step(input int d);
      int qs;
      qs = (d == 0) ? q0.size() : q1.size();
      if (rst[d]) begin
         if (d == 0) q0.delete(); else q1.delete();
         cur[d] = mk(1, 1, 1, 0, 0, 0, 0, 8'd0);
      end else begin
         if (qs == 0 && cur[d].rdy && req[d]) build(d, dir[d], cnt[d]);
         qs = (d == 0) ? q0.size() : q1.size();
         if (qs > 0) cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
         else        cur[d] = mk(1, 1, 1, 0, 0, 0, 0, cur[d].rem);
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      model_on = 1'b1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("cycle_dut", 32'(act0), 32'(cur[0]));
         chk("cycle_loop", 32'(act1), 32'(cur[1]));
      end
   end

   // ---------------- rotary direction decoder on the loopback instance ----------------
   logic [1:0] dec[$];
   logic       prev_a1 = 1'b1;
   int         done1_n = 0;
   always @(negedge clk) begin
      if (sia1 && !prev_a1) dec.push_back(sib1 ? 2'b01 : 2'b10);
      prev_a1 = sia1;
      if (done1) done1_n++;
   end

   // ---------------- directed helpers ----------------
   logic [1:0] t_ab   [0:79];
   logic       t_step [0:79];
   logic       t_done [0:79];
   logic       t_rdy  [0:79];
   logic       t_err  [0:79];
   logic [7:0] t_rem  [0:79];

   task automatic wait_idle0();
      int b;
      b = 0;
      @(negedge clk);
      while (!ready0 && b < 500) begin
         @(negedge clk);
         b++;
      end
      if (!ready0) chk("idle_timeout", 32'(ready0), 32'd1);
   endtask

   task automatic run0(input logic [1:0] d, input logic [7:0] n, input int len);
      wait_idle0();
      req[0] = 1'b1; dir[0] = d; cnt[0] = n;
      @(negedge clk);
      req[0] = 1'b0;
      for (int j = 1; j <= len; j++) begin
         t_ab[j] = {sia0, sib0}; t_step[j] = step0; t_done[j] = done0;
         t_rdy[j] = ready0; t_err[j] = err0; t_rem[j] = rem0;
         if (j < len) @(negedge clk);
      end
   endtask

   task automatic loop_cmd(input logic [1:0] d);
      int b;
      b = 0;
      @(negedge clk);
      while (!ready1 && b < 200) begin
         @(negedge clk);
         b++;
      end
      req[1] = 1'b1; dir[1] = d; cnt[1] = 8'd2;
      @(negedge clk);
      b = 0;
      while (busy1 && b < 200) begin
         req[1] = ~req[1];
         dir[1] = 2'($urandom);
         cnt[1] = 8'($urandom);
         @(negedge clk);
         b++;
      end
      req[1] = 1'b0;
      if (busy1) chk("loop_timeout", 32'(busy1), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps;
      int edges;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; dir[d] = 2'b01; cnt[d] = 8'd0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ab", {sia0, sib0}, 32'd3);
      chk("rst_ready", 32'(ready0), 32'd1);
      chk("rst_busy_step_done_err", {busy0, step0, done0, err0}, 32'd0);
      chk("rst_remain", 32'(rem0), 32'd0);
      rst[0] = 1'b0; rst[1] = 1'b0;

      // right, one detent
      run0(2'b01, 8'd1, 18);
      chk("t1_ab1", t_ab[1], 32'd2);
      chk("t1_ab4", t_ab[4], 32'd2);
      chk("t1_ab5", t_ab[5], 32'd0);
      chk("t1_ab9", t_ab[9], 32'd1);
      chk("t1_ab13", t_ab[13], 32'd3);
      chk("t1_step12", 32'(t_step[12]), 32'd0);
      chk("t1_step13", 32'(t_step[13]), 32'd1);
      chk("t1_done17", 32'(t_done[17]), 32'd1);
      chk("t1_ready17", 32'(t_rdy[17]), 32'd0);
      chk("t1_ready18", 32'(t_rdy[18]), 32'd1);

      // left, three detents with gaps
      run0(2'b10, 8'd3, 66);
      chk("t2_ab1", t_ab[1], 32'd1);
      chk("t2_ab5", t_ab[5], 32'd0);
      chk("t2_ab9", t_ab[9], 32'd2);
      chk("t2_ab20_gap", t_ab[20], 32'd3);
      steps = 0;
      for (int j = 1; j <= 66; j++) if (t_step[j]) steps++;
      chk("t2_step_count", steps, 32'd3);
      chk("t2_step13", 32'(t_step[13]), 32'd1);
      chk("t2_step37", 32'(t_step[37]), 32'd1);
      chk("t2_step61", 32'(t_step[61]), 32'd1);
      chk("t2_done65", 32'(t_done[65]), 32'd1);
      chk("t2_rem1", t_rem[1], 32'd3);
      chk("t2_rem17", t_rem[17], 32'd2);
      chk("t2_rem41", t_rem[41], 32'd1);
      chk("t2_rem65", t_rem[65], 32'd0);

      // illegal directions
      run0(2'b11, 8'd5, 2);
      chk("t3_err", 32'(t_err[1]), 32'd1);
      chk("t3_done", 32'(t_done[1]), 32'd1);
      chk("t3_ab", t_ab[1], 32'd3);
      chk("t3_ready2", 32'(t_rdy[2]), 32'd1);
      run0(2'b00, 8'd5, 2);
      chk("t3b_err", 32'(t_err[1]), 32'd1);
      chk("t3b_done", 32'(t_done[1]), 32'd1);
      chk("t3b_ready2", 32'(t_rdy[2]), 32'd1);

      // zero count
      run0(2'b01, 8'd0, 3);
      chk("t4_done", 32'(t_done[1]), 32'd1);
      chk("t4_err", 32'(t_err[1]), 32'd0);
      edges = 0;
      for (int j = 1; j <= 3; j++) if (t_ab[j] != 2'b11) edges++;
      chk("t4_no_edges", edges, 32'd0);
      chk("t4_ready2", 32'(t_rdy[2]), 32'd1);

      // reset during PH2 of a four-detent command
      wait_idle0();
      req[0] = 1'b1; dir[0] = 2'b01; cnt[0] = 8'd4;
      @(negedge clk);
      req[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_in_ph2", {sia0, sib0}, 32'd0);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("t5_ab", {sia0, sib0}, 32'd3);
      chk("t5_ready", 32'(ready0), 32'd1);
      chk("t5_remain", 32'(rem0), 32'd0);
      chk("t5_done", 32'(done0), 32'd0);
      run0(2'b01, 8'd1, 18);
      chk("t5_new_ab1", t_ab[1], 32'd2);
      chk("t5_new_done17", 32'(t_done[17]), 32'd1);

      // loopback through the rotary direction decoder
      loop_cmd(2'b01);
      loop_cmd(2'b10);
      chk("loop_dec_count", dec.size(), 32'd4);
      if (dec.size() == 4) begin
         chk("loop_dec0", dec[0], 32'd1);
         chk("loop_dec1", dec[1], 32'd1);
         chk("loop_dec2", dec[2], 32'd2);
         chk("loop_dec3", dec[3], 32'd2);
      end
      chk("loop_done_count", done1_n, 32'd2);

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            req[d] = 1'($urandom_range(0, 1));
            dir[d] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
            cnt[d] = 8'($urandom_range(0, 4));
            rst[d] = ($urandom_range(0, 149) == 0);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; rst[d] = 1'b0;
      end
      wait_idle0();
      repeat (150) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
